// File: rtl/wb_arb_pkg.sv
// Shared definitions for the writeback arbiter slice.
// Holds the register-address and data widths, the idle address and a helper
// that decides whether a writeback slot carries a real register write.
package wb_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int WORD_W     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [WORD_W-1:0]     word_t;

  // r0 writes are discarded by the register file, so address 0 doubles as "idle".
  localparam reg_addr_t IDLE_ADDR = '0;

  function automatic logic slot_busy(input logic valid, input reg_addr_t addr);
    return valid && (addr != IDLE_ADDR);
  endfunction

endpackage

// File: rtl/wb_arb_if.sv
// Bus bundle between the pipeline/mul-div side (master) and wb_arb (slave).
//   Pipe_valid/Pipe_addr/Pipe_data : pipeline writeback slot
//   Md_valid/Md_ready/Md_addr/Md_data : mul/div result offer
//   RDaddr/RD                      : registered register-file write port
//   Pend                           : per-register outstanding buffered write bitmap
//   Stall                          : request to freeze the pipeline writeback slot
//
// Md handshake: the master holds Md_valid/Md_addr/Md_data stable until it sees
// Md_ready=1 at a rising edge; a transfer happens exactly on an edge where
// Md_valid and Md_ready are both 1. Md_ready never depends on Md_valid.
interface wb_arb_if;

  logic                  Pipe_valid;
  wb_arb_pkg::reg_addr_t Pipe_addr;
  wb_arb_pkg::word_t     Pipe_data;
  logic                  Md_valid;
  logic                  Md_ready;
  wb_arb_pkg::reg_addr_t Md_addr;
  wb_arb_pkg::word_t     Md_data;
  wb_arb_pkg::reg_addr_t RDaddr;
  wb_arb_pkg::word_t     RD;
  logic [31:0]           Pend;
  logic                  Stall;

  modport master (
    output Pipe_valid, Pipe_addr, Pipe_data, Md_valid, Md_addr, Md_data,
    input  Md_ready, RDaddr, RD, Pend, Stall
  );

  modport slave (
    input  Pipe_valid, Pipe_addr, Pipe_data, Md_valid, Md_addr, Md_data,
    output Md_ready, RDaddr, RD, Pend, Stall
  );

endinterface

// File: rtl/wb_fifo.sv
// Small FIFO buffering mul/div results until the writeback port is free.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   push_i/addr_i/data_i : write a new entry (caller pushes only when not full)
//   pop_i              : retire the head entry (caller pops only when not empty)
//   head_addr_o/data_o : head entry contents
//   full_o/empty_o/count_o : occupancy
//   entry_vld_o/entry_addr_o : per-slot occupancy and target, for Pend decode
module wb_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  reg_addr_t                addr_i,
  input  word_t                    data_i,
  input  logic                     pop_i,
  output reg_addr_t                head_addr_o,
  output word_t                    head_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [DEPTH-1:0]         entry_vld_o,
  output reg_addr_t                entry_addr_o [DEPTH]
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PW:0]    count_q, count_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  reg_addr_t      addr_q [DEPTH];
  word_t          data_q [DEPTH];

  // Pointers are PW bits wide, so with a power-of-two DEPTH they wrap for free.
  always_comb begin
    vld_d = vld_q;
    if (pop_i)  vld_d[rd_ptr_q] = 1'b0;
    if (push_i) vld_d[wr_ptr_q] = 1'b1;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      vld_q   <= vld_d;
    end
  end

  // Payload storage needs no reset: every consumer qualifies it with vld_q.
  always_ff @(posedge clk_i) begin
    if (push_i && !rst_i) begin
      addr_q[wr_ptr_q] <= addr_i;
      data_q[wr_ptr_q] <= data_i;
    end
  end

  assign head_addr_o  = addr_q[rd_ptr_q];
  assign head_data_o  = data_q[rd_ptr_q];
  assign count_o      = count_q;
  assign full_o       = (count_q == (PW+1)'(DEPTH));
  assign empty_o      = (count_q == '0);
  assign entry_vld_o  = vld_q;
  assign entry_addr_o = addr_q;

endmodule

// File: rtl/wb_arb.sv
// Writeback arbiter: merges the pipeline writeback slot and buffered mul/div
// results onto a single registered register-file write port.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : wb_arb_if.slave (pipe slot, Md handshake, RDaddr/RD, Pend, Stall)
// The pipe slot always wins; buffered results drain in FIFO order when the
// slot is idle, and Stall asks upstream for a free slot once the head has
// waited STARVE_MAX cycles.
module wb_arb
  import wb_arb_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic     CLK,
  input  logic     RST,
  wb_arb_if.slave  bus
);

  localparam int          CW        = $clog2(DEPTH);
  localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);

  logic            pipe_busy, md_ready, md_push, pop;
  reg_addr_t       head_addr;
  word_t           head_data;
  logic            fifo_full, fifo_empty;
  logic [CW:0]     fifo_count;
  logic [DEPTH-1:0] entry_vld;
  reg_addr_t       entry_addr [DEPTH];

  reg_addr_t       rdaddr_q, rdaddr_d;
  word_t           rd_q, rd_d;
  logic [3:0]      wait_q, wait_d;
  logic            stall_q, stall_d;
  logic [31:0]     pend;

  assign pipe_busy = slot_busy(bus.Pipe_valid, bus.Pipe_addr);
  // Held low during reset so no offer is consumed while state is being cleared.
  assign md_ready  = !RST && (fifo_count < (CW+1)'(DEPTH));
  // Address-0 offers complete the handshake but never occupy a slot.
  assign md_push   = bus.Md_valid && md_ready && !fifo_full &&
                     (bus.Md_addr != IDLE_ADDR);
  assign pop       = !pipe_busy && !fifo_empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i        (CLK),
    .rst_i        (RST),
    .push_i       (md_push),
    .addr_i       (bus.Md_addr),
    .data_i       (bus.Md_data),
    .pop_i        (pop),
    .head_addr_o  (head_addr),
    .head_data_o  (head_data),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (fifo_count),
    .entry_vld_o  (entry_vld),
    .entry_addr_o (entry_addr)
  );

  always_comb begin
    rdaddr_d = IDLE_ADDR;
    rd_d     = '0;
    if (pipe_busy) begin
      rdaddr_d = bus.Pipe_addr;
      rd_d     = bus.Pipe_data;
    end else if (pop) begin
      rdaddr_d = head_addr;
      rd_d     = head_data;
    end
  end

  // Wait counter tracks how long the current head has been blocked; Stall is
  // raised once it has sat at the limit and drops as soon as the head pops.
  always_comb begin
    wait_d  = wait_q;
    stall_d = 1'b0;
    if (fifo_empty || pop) begin
      wait_d = '0;
    end else begin
      if (wait_q != STARVE_LIM) wait_d = wait_q + 1'b1;
      stall_d = (wait_q == STARVE_LIM);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rdaddr_q <= IDLE_ADDR;
      rd_q     <= '0;
      wait_q   <= '0;
      stall_q  <= 1'b0;
    end else begin
      rdaddr_q <= rdaddr_d;
      rd_q     <= rd_d;
      wait_q   <= wait_d;
      stall_q  <= stall_d;
    end
  end

  // Pend is decoded from live FIFO slots, so a register stays pending while
  // any buffered entry still targets it.
  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_vld[i]) pend[entry_addr[i]] = 1'b1;
    end
    pend[0] = 1'b0;
  end

  assign bus.Md_ready = md_ready;
  assign bus.RDaddr   = rdaddr_q;
  assign bus.RD       = rd_q;
  assign bus.Pend     = pend;
  assign bus.Stall    = stall_q;

endmodule

// File: tb/tb_wb_arb.sv
// Testbench for wb_arb: directed cycles, expected writes queued at issue time,
// a negedge monitor compares every emitted write against the queue.
module tb_wb_arb;
  import wb_arb_pkg::*;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_arb_if bus();

  wb_arb #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  // ---------------- scoreboard state ----------------
  logic [36:0] exp_q[$];
  logic [36:0] mon_exp;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic expect_wr(input reg_addr_t a, input word_t d);
    exp_q.push_back({a, d});
  endtask

  // Drive one cycle of inputs, then return just after the capturing edge.
  task automatic cyc(input logic pv, input reg_addr_t pa, input word_t pd,
                     input logic mv, input reg_addr_t ma, input word_t md);
    bus.Pipe_valid = pv;
    bus.Pipe_addr  = pa;
    bus.Pipe_data  = pd;
    bus.Md_valid   = mv;
    bus.Md_addr    = ma;
    bus.Md_data    = md;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (bus.RDaddr != IDLE_ADDR) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %h expected no write",
                 bus.RDaddr, bus.RD);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({bus.RDaddr, bus.RD} !== mon_exp) begin
          errors++;
          $display("FAIL write_order: got addr %0d data %h expected addr %0d data %h",
                   bus.RDaddr, bus.RD, mon_exp[36:32], mon_exp[31:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1;
    bus.Pipe_valid = 1'b0; bus.Pipe_addr = '0; bus.Pipe_data = '0;
    bus.Md_valid   = 1'b0; bus.Md_addr   = '0; bus.Md_data   = '0;
    @(posedge clk); #1;
    check("ready_in_reset", 32'(bus.Md_ready), 32'd0);
    @(posedge clk); #1;
    check("rdaddr_reset", 32'(bus.RDaddr), 32'd0);
    check("rd_reset", bus.RD, 32'd0);
    check("pend_reset", bus.Pend, 32'd0);
    check("stall_reset", 32'(bus.Stall), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_reset", 32'(bus.Md_ready), 32'd1);

    // Single pipe write, one cycle latency, one cycle wide.
    expect_wr(5'd5, 32'hDEADBEEF);
    cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    check("pipe_addr", 32'(bus.RDaddr), 32'd5);
    check("pipe_data", bus.RD, 32'hDEADBEEF);
    idle();
    check("pipe_addr_drop", 32'(bus.RDaddr), 32'd0);

    // Single mul/div result through the buffer.
    expect_wr(5'd9, 32'h12);
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h12);
    check("pend9_set", bus.Pend, 32'h0000_0200);
    check("md_not_yet", 32'(bus.RDaddr), 32'd0);
    idle();
    check("md_addr", 32'(bus.RDaddr), 32'd9);
    check("md_data", bus.RD, 32'h12);
    check("pend9_clr", bus.Pend, 32'd0);
    idle();
    check("md_addr_drop", 32'(bus.RDaddr), 32'd0);

    // Buffer fills behind a busy pipe, third offer is held, then drains in order.
    expect_wr(5'd1, 32'hA1);
    expect_wr(5'd2, 32'hA2);
    expect_wr(5'd4, 32'hA4);
    expect_wr(5'd10, 32'h100);
    expect_wr(5'd11, 32'h101);
    expect_wr(5'd12, 32'h102);
    cyc(1'b1, 5'd1, 32'hA1, 1'b1, 5'd10, 32'h100);
    check("ready_one_entry", 32'(bus.Md_ready), 32'd1);
    cyc(1'b1, 5'd2, 32'hA2, 1'b1, 5'd11, 32'h101);
    check("ready_full", 32'(bus.Md_ready), 32'd0);
    check("pend_full", bus.Pend, 32'h0000_0C00);
    cyc(1'b1, 5'd4, 32'hA4, 1'b1, 5'd12, 32'h102);
    check("ready_held", 32'(bus.Md_ready), 32'd0);
    check("pend_held", bus.Pend, 32'h0000_0C00);
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'h102);
    check("drain_first", 32'(bus.RDaddr), 32'd10);
    check("ready_after_pop", 32'(bus.Md_ready), 32'd1);
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'h102);
    check("drain_second", 32'(bus.RDaddr), 32'd11);
    check("pend_push_pop", bus.Pend, 32'h0000_1000);
    idle();
    check("drain_third", 32'(bus.RDaddr), 32'd12);
    check("pend_drained", bus.Pend, 32'd0);

    // Starvation: head blocked by a busy pipe until Stall rises.
    expect_wr(5'd3, 32'hB0);
    for (int i = 1; i <= 5; i++) expect_wr(5'd3, 32'hB0 + 32'(i));
    expect_wr(5'd20, 32'h200);
    cyc(1'b1, 5'd3, 32'hB0, 1'b1, 5'd20, 32'h200);
    for (int i = 1; i <= 4; i++) cyc(1'b1, 5'd3, 32'hB0 + 32'(i), 1'b0, 5'd0, 32'h0);
    check("stall_not_yet", 32'(bus.Stall), 32'd0);
    cyc(1'b1, 5'd3, 32'hB5, 1'b0, 5'd0, 32'h0);
    check("stall_set", 32'(bus.Stall), 32'd1);
    idle();
    check("starved_head", 32'(bus.RDaddr), 32'd20);
    check("stall_clr", 32'(bus.Stall), 32'd0);

    // Address-0 traffic never reaches the write port.
    check("ready_zero_addr", 32'(bus.Md_ready), 32'd1);
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55);
    check("pend_zero_addr", bus.Pend, 32'd0);
    idle();
    check("rd_zero_md", 32'(bus.RDaddr), 32'd0);
    cyc(1'b1, 5'd0, 32'h77, 1'b0, 5'd0, 32'h0);
    check("rd_zero_pipe", 32'(bus.RDaddr), 32'd0);
    check("rd_zero_pipe_data", bus.RD, 32'd0);

    // Reset with two buffered entries: they must vanish.
    expect_wr(5'd6, 32'hC0);
    expect_wr(5'd7, 32'hC1);
    cyc(1'b1, 5'd6, 32'hC0, 1'b1, 5'd21, 32'h300);
    cyc(1'b1, 5'd7, 32'hC1, 1'b1, 5'd22, 32'h301);
    check("pend_two", bus.Pend, 32'h0060_0000);
    rst = 1'b1;
    bus.Pipe_valid = 1'b0; bus.Pipe_addr = '0; bus.Md_valid = 1'b0; bus.Md_addr = '0;
    #1;
    check("ready_rst_pulse", 32'(bus.Md_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("pend_after_rst", bus.Pend, 32'd0);
    check("stall_after_rst", 32'(bus.Stall), 32'd0);
    check("rdaddr_after_rst", 32'(bus.RDaddr), 32'd0);
    for (int i = 0; i < 4; i++) begin
      idle();
      check("no_ghost_write", 32'(bus.RDaddr), 32'd0);
    end

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_arb.md
WB_ARB -- requirements
Module: wb_arb

Interface
REQ-001 Parameter DEPTH, default 2, number of entries in the multi-cycle result buffer (power of two, >=2).
REQ-002 Parameter STARVE_MAX, default 4, consecutive cycles a buffered result may wait before Stall asserts (1..15).
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 Pipe_valid  input  1  pipeline writeback slot carries a result this cycle.
REQ-006 Pipe_addr  input  5  pipeline destination register; 0 means no write.
REQ-007 Pipe_data  input  32  pipeline result.
REQ-008 Md_valid  input  1  mul/div unit offers a result.
REQ-009 Md_ready  output  1  buffer accepts the offered result this cycle.
REQ-010 Md_addr  input  5  mul/div destination register.
REQ-011 Md_data  input  32  mul/div result.
REQ-012 RDaddr  output  5  register file write address; 0 = idle, since r0 writes are discarded.
REQ-013 RD  output  32  register file write data.
REQ-014 Pend  output  32  bitmap; bit n set while a buffered mul/div write to rn is outstanding.
REQ-015 Stall  output  1  request to freeze the pipeline writeback slot.

Function
REQ-016 RDaddr/RD SHALL be registered; a write selected in cycle N appears on RDaddr/RD in cycle N+1 for exactly one cycle.
REQ-017 A pipe slot SHALL count as busy when Pipe_valid=1 and Pipe_addr!=0; a non-busy slot SHALL NOT reach RDaddr.
REQ-018 Selection priority each cycle: busy pipe slot first; otherwise the buffer head, if the buffer is non-empty; otherwise idle (RDaddr=0, RD=0).
REQ-019 Md_ready SHALL equal (count<DEPTH) combinationally; a handshake occurs when Md_valid and Md_ready are both 1.
REQ-020 A handshake with Md_addr=0 SHALL be accepted and discarded: no buffer entry, no Pend change.
REQ-021 Buffered entries SHALL drain in FIFO order; pointers wrap modulo DEPTH.
REQ-022 A simultaneous push and pop on a full buffer SHALL NOT occur, because Md_ready=0 when full; a push and pop in the same cycle on a partly full buffer SHALL leave the count unchanged.
REQ-023 Pend[n] SHALL set in the cycle after a push to rn. It SHALL clear in the cycle after that entry's pop, unless another buffered entry still targets rn. Pend[0] SHALL always be 0.
REQ-024 Wait counter: it SHALL increment each cycle the buffer is non-empty and the head is not popped. It SHALL reset to 0 on a pop or when the buffer is empty. It SHALL saturate at STARVE_MAX.
REQ-025 Stall SHALL be registered; it SHALL be 1 in the cycle after the wait counter reaches STARVE_MAX, and SHALL drop in the cycle after the head is popped.
REQ-026 While Stall=1, upstream SHALL present a non-busy slot. If a busy slot arrives during Stall, it still wins, and the violation is a checker error.
REQ-027 Write-ordering hazards between pipe and buffered writes to the same register SHALL be prevented upstream using Pend; wb_arb SHALL NOT reorder or merge writes.

Reset
REQ-028 While RST=1 at a clock edge: buffer emptied, wait counter=0, RDaddr=0, RD=0, Pend=0, Stall=0.
REQ-029 Md_ready SHALL be 0 while RST=1, so no handshake is lost or accepted during reset.
REQ-030 A reset mid-operation SHALL discard buffered results and SHALL NOT emit a partial write.

Structure
REQ-031 A shared package SHALL hold REG_ADDR_W=5, WORD_W=32, and the idle-address constant 0.
REQ-032 The buffer SHALL be a sub-module wb_fifo (parameter DEPTH; push/pop/full/empty/count; head data and address).
REQ-033 Pend SHALL be derived in wb_arb from per-entry valid/address decode; no separate scoreboard RAM.

Verification
REQ-034 Pipe_valid=1, addr=5, data=0xDEADBEEF, buffer empty -> next cycle RDaddr=5, RD=0xDEADBEEF; following cycle RDaddr=0.
REQ-035 Md push addr=9, data=0x12, pipe idle -> Pend[9]=1 one cycle later, then RDaddr=9/RD=0x12, then Pend[9]=0.
REQ-036 Two Md pushes (DEPTH=2) with the pipe busy -> Md_ready=0; third offer held. After the pipe idles, the writes drain in push order.
REQ-037 Buffer non-empty, pipe busy on addr 3 for 5 consecutive cycles (STARVE_MAX=4) -> Stall=1 from cycle 5. Pipe then idle -> head written, Stall=0 next cycle.
REQ-038 Md push with Md_addr=0 -> accepted (Md_ready=1), no write, Pend unchanged; Pipe_valid=1 with addr=0 -> RDaddr stays 0.
REQ-039 Two entries buffered, RST pulsed for one cycle -> Pend=0, Stall=0, RDaddr=0, and no buffered write ever emitted.
